// File: rtl/axioma_pkg.sv
// Shared definitions for the AxiomaCore-328 decode path: ALU opcodes, branch
// conditions, opcode mask/value pairs, FSM states and the decoded bundle type.
package axioma_pkg;

    localparam logic [4:0] ALU_ADD  = 5'h00;
    localparam logic [4:0] ALU_ADC  = 5'h01;
    localparam logic [4:0] ALU_SUB  = 5'h02;
    localparam logic [4:0] ALU_AND  = 5'h04;
    localparam logic [4:0] ALU_OR   = 5'h05;
    localparam logic [4:0] ALU_EOR  = 5'h06;
    localparam logic [4:0] ALU_CP   = 5'h11;
    localparam logic [4:0] ALU_PASS = 5'h1F;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;

    localparam logic [15:0] MASK_RR  = 16'hFC00;
    localparam logic [15:0] MASK_IMM = 16'hF000;
    localparam logic [15:0] MASK_BR  = 16'hFC07;
    localparam logic [15:0] MASK_JMP = 16'hFE0E;
    localparam logic [15:0] MASK_MEM = 16'hFE0F;

    localparam logic [15:0] OP_NOP  = 16'h0000;
    localparam logic [15:0] OP_ADD  = 16'h0C00;
    localparam logic [15:0] OP_ADC  = 16'h1C00;
    localparam logic [15:0] OP_SUB  = 16'h1800;
    localparam logic [15:0] OP_AND  = 16'h2000;
    localparam logic [15:0] OP_EOR  = 16'h2400;
    localparam logic [15:0] OP_OR   = 16'h2800;
    localparam logic [15:0] OP_MOV  = 16'h2C00;
    localparam logic [15:0] OP_LDI  = 16'hE000;
    localparam logic [15:0] OP_CPI  = 16'h3000;
    localparam logic [15:0] OP_RJMP = 16'hC000;
    localparam logic [15:0] OP_BREQ = 16'hF001;
    localparam logic [15:0] OP_BRNE = 16'hF401;
    localparam logic [15:0] OP_JMP  = 16'h940C;
    localparam logic [15:0] OP_CALL = 16'h940E;
    localparam logic [15:0] OP_LDS  = 16'h9000;
    localparam logic [15:0] OP_STS  = 16'h9200;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_K2
    } state_t;

    typedef struct packed {
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_write_en;
        logic [4:0]  alu_op;
        logic        alu_use_imm;
        logic [7:0]  immediate;
        logic        mem_read;
        logic        mem_write;
        logic [15:0] mem_addr;
        logic        branch_en;
        logic [2:0]  branch_cond;
        logic [11:0] branch_offset;
        logic        jump_en;
        logic        jump_rel;
        logic        is_call;
        logic [21:0] jump_addr;
        logic        word_count;
        logic        unsupported;
    } decode_t;

    function automatic decode_t idle_bundle();
        decode_t b;
        b        = '0;
        b.alu_op = ALU_PASS;
        return b;
    endfunction

    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & MASK_JMP) == OP_JMP) || ((w & MASK_JMP) == OP_CALL) ||
               ((w & MASK_MEM) == OP_LDS) || ((w & MASK_MEM) == OP_STS);
    endfunction

endpackage

// File: rtl/axioma_decode_comb.sv
// Pure combinational decode of an AVR instruction; word2 is only meaningful
// for the two-word forms (JMP, CALL, LDS, STS).
module axioma_decode_comb
    import axioma_pkg::*;
#(
    parameter bit ENABLE_32BIT = 1'b1
) (
    input  logic [15:0] word1,
    input  logic [15:0] word2,
    output decode_t     dec
);

    logic       rr_hit;
    logic [4:0] rr_op;

    always_comb begin
        dec    = idle_bundle();
        rr_hit = 1'b1;
        rr_op  = ALU_ADD;
        case (word1 & MASK_RR)
            OP_ADD:  rr_op = ALU_ADD;
            OP_ADC:  rr_op = ALU_ADC;
            OP_SUB:  rr_op = ALU_SUB;
            OP_AND:  rr_op = ALU_AND;
            OP_EOR:  rr_op = ALU_EOR;
            OP_OR:   rr_op = ALU_OR;
            default: rr_hit = 1'b0;
        endcase

        if (word1 == OP_NOP) begin
            dec = idle_bundle();
        end else if (rr_hit) begin
            dec.rd_addr     = word1[8:4];
            dec.rs1_addr    = word1[8:4];
            dec.rs2_addr    = {word1[9], word1[3:0]};
            dec.rd_write_en = 1'b1;
            dec.alu_op      = rr_op;
        end else if ((word1 & MASK_RR) == OP_MOV) begin
            dec.rd_addr     = word1[8:4];
            dec.rs1_addr    = {word1[9], word1[3:0]};
            dec.rd_write_en = 1'b1;
        end else if ((word1 & MASK_IMM) == OP_LDI) begin
            dec.rd_addr     = {1'b1, word1[7:4]};
            dec.immediate   = {word1[11:8], word1[3:0]};
            dec.alu_use_imm = 1'b1;
            dec.rd_write_en = 1'b1;
        end else if ((word1 & MASK_IMM) == OP_CPI) begin
            dec.rs1_addr    = {1'b1, word1[7:4]};
            dec.immediate   = {word1[11:8], word1[3:0]};
            dec.alu_use_imm = 1'b1;
            dec.alu_op      = ALU_CP;
        end else if ((word1 & MASK_IMM) == OP_RJMP) begin
            dec.jump_en   = 1'b1;
            dec.jump_rel  = 1'b1;
            dec.jump_addr = {{10{word1[11]}}, word1[11:0]};
        end else if ((word1 & MASK_BR) == OP_BREQ || (word1 & MASK_BR) == OP_BRNE) begin
            dec.branch_en     = 1'b1;
            dec.branch_cond   = ((word1 & MASK_BR) == OP_BREQ) ? BR_EQ : BR_NE;
            dec.branch_offset = {{5{word1[9]}}, word1[9:3]};
        end else if (ENABLE_32BIT && ((word1 & MASK_JMP) == OP_JMP || (word1 & MASK_JMP) == OP_CALL)) begin
            dec.jump_en    = 1'b1;
            dec.is_call    = ((word1 & MASK_JMP) == OP_CALL);
            dec.jump_addr  = {word1[8:4], word1[0], word2};
            dec.word_count = 1'b1;
        end else if (ENABLE_32BIT && (word1 & MASK_MEM) == OP_LDS) begin
            dec.rd_addr     = word1[8:4];
            dec.rd_write_en = 1'b1;
            dec.mem_read    = 1'b1;
            dec.mem_addr    = word2;
            dec.word_count  = 1'b1;
        end else if (ENABLE_32BIT && (word1 & MASK_MEM) == OP_STS) begin
            dec.rs1_addr   = word1[8:4];
            dec.mem_write  = 1'b1;
            dec.mem_addr   = word2;
            dec.word_count = 1'b1;
        end else begin
            dec.unsupported = 1'b1;
        end
    end

endmodule

// File: rtl/axioma_decode_stage.sv
// Registered valid/ready decode stage: assembles two-word instructions and
// holds one decoded bundle until the execute stage takes it.
module axioma_decode_stage
    import axioma_pkg::*;
#(
    parameter int PC_W         = 14,
    parameter bit ENABLE_32BIT = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic [15:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic            rd_write_en,
    output logic [4:0]      alu_op,
    output logic            alu_use_imm,
    output logic [7:0]      immediate,
    output logic            mem_read,
    output logic            mem_write,
    output logic [15:0]     mem_addr,
    output logic            branch_en,
    output logic [2:0]      branch_cond,
    output logic [11:0]     branch_offset,
    output logic            jump_en,
    output logic            jump_rel,
    output logic            is_call,
    output logic [21:0]     jump_addr,
    output logic            word_count,
    output logic            unsupported
);

    state_t          state_q, state_d;
    logic [15:0]     word1_q, word1_d;
    logic [PC_W-1:0] pc1_q, pc1_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;
    logic            out_valid_q, out_valid_d;
    decode_t         bundle_q, bundle_d;
    decode_t         dec;
    logic [15:0]     dec_w1, dec_w2;
    logic            accept;

    assign in_ready = reset_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign dec_w1   = (state_q == ST_WAIT_K2) ? word1_q : in_instr;
    assign dec_w2   = (state_q == ST_WAIT_K2) ? in_instr : 16'h0000;

    axioma_decode_comb #(
        .ENABLE_32BIT(ENABLE_32BIT)
    ) u_decode_comb (
        .word1(dec_w1),
        .word2(dec_w2),
        .dec  (dec)
    );

    // Flush wins over everything; a consumed bundle can be replaced in the same cycle.
    always_comb begin
        state_d     = state_q;
        word1_d     = word1_q;
        pc1_d       = pc1_q;
        out_pc_d    = out_pc_q;
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q && !out_ready;
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else if (accept) begin
            if (ENABLE_32BIT && state_q == ST_IDLE && is_two_word(in_instr)) begin
                state_d = ST_WAIT_K2;
                word1_d = in_instr;
                pc1_d   = in_pc;
            end else begin
                state_d     = ST_IDLE;
                bundle_d    = dec;
                out_pc_d    = (state_q == ST_WAIT_K2) ? pc1_q : in_pc;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            word1_q     <= '0;
            pc1_q       <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= idle_bundle();
        end else begin
            state_q     <= state_d;
            word1_q     <= word1_d;
            pc1_q       <= pc1_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign rs1_addr      = bundle_q.rs1_addr;
    assign rs2_addr      = bundle_q.rs2_addr;
    assign rd_addr       = bundle_q.rd_addr;
    assign rd_write_en   = bundle_q.rd_write_en;
    assign alu_op        = bundle_q.alu_op;
    assign alu_use_imm   = bundle_q.alu_use_imm;
    assign immediate     = bundle_q.immediate;
    assign mem_read      = bundle_q.mem_read;
    assign mem_write     = bundle_q.mem_write;
    assign mem_addr      = bundle_q.mem_addr;
    assign branch_en     = bundle_q.branch_en;
    assign branch_cond   = bundle_q.branch_cond;
    assign branch_offset = bundle_q.branch_offset;
    assign jump_en       = bundle_q.jump_en;
    assign jump_rel      = bundle_q.jump_rel;
    assign is_call       = bundle_q.is_call;
    assign jump_addr     = bundle_q.jump_addr;
    assign word_count    = bundle_q.word_count;
    assign unsupported   = bundle_q.unsupported;

endmodule

// File: tb/tb_axioma_decode_stage.sv
// Directed bench for axioma_decode_stage: hand-computed bundles, backpressure,
// flush and reset while waiting for the second instruction word.
module tb_axioma_decode_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [15:0] in_instr;
    logic [13:0] in_pc;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_pc;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_write_en;
    logic [4:0]  alu_op;
    logic        alu_use_imm;
    logic [7:0]  immediate;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr;
    logic        branch_en;
    logic [2:0]  branch_cond;
    logic [11:0] branch_offset;
    logic        jump_en, jump_rel, is_call;
    logic [21:0] jump_addr;
    logic        word_count;
    logic        unsupported;

    int checks   = 0;
    int failures = 0;

    axioma_decode_stage #(
        .PC_W(14),
        .ENABLE_32BIT(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_instr(in_instr), .in_pc(in_pc), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rd_write_en(rd_write_en), .alu_op(alu_op), .alu_use_imm(alu_use_imm),
        .immediate(immediate), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .branch_en(branch_en), .branch_cond(branch_cond),
        .branch_offset(branch_offset), .jump_en(jump_en), .jump_rel(jump_rel),
        .is_call(is_call), .jump_addr(jump_addr), .word_count(word_count),
        .unsupported(unsupported)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] instr, input logic [13:0] pc, input logic valid);
        in_instr = instr;
        in_pc    = pc;
        in_valid = valid;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [15:0] instr, input logic [13:0] pc);
        applyStimulus(instr, pc, 1'b1);
        stepCycle();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(16'h0000, 14'h0, 1'b0);
        #12;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_alu_op", alu_op, 32'h1F);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_rd_addr", rd_addr, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", in_ready, 1);

        // ADD R1,R2
        sendWord(16'h0C12, 14'h005);
        checkOutput("add_out_valid", out_valid, 1);
        checkOutput("add_rd", rd_addr, 1);
        checkOutput("add_rs1", rs1_addr, 1);
        checkOutput("add_rs2", rs2_addr, 2);
        checkOutput("add_alu_op", alu_op, 0);
        checkOutput("add_rd_we", rd_write_en, 1);
        checkOutput("add_word_count", word_count, 0);
        checkOutput("add_out_pc", out_pc, 32'h005);

        // LDI R16,0xAB
        sendWord(16'hEA0B, 14'h006);
        checkOutput("ldi_rd", rd_addr, 16);
        checkOutput("ldi_imm", immediate, 32'hAB);
        checkOutput("ldi_use_imm", alu_use_imm, 1);
        checkOutput("ldi_alu_op", alu_op, 32'h1F);

        // JMP 0x000123: no bundle for word 1
        sendWord(16'h940C, 14'h010);
        checkOutput("jmp_w1_no_bundle", out_valid, 0);
        sendWord(16'h0123, 14'h011);
        checkOutput("jmp_out_valid", out_valid, 1);
        checkOutput("jmp_addr", jump_addr, 32'h000123);
        checkOutput("jmp_rel", jump_rel, 0);
        checkOutput("jmp_en", jump_en, 1);
        checkOutput("jmp_out_pc", out_pc, 32'h010);
        checkOutput("jmp_word_count", word_count, 1);

        // BREQ -2 and an unknown word
        sendWord(16'hF3F1, 14'h012);
        checkOutput("breq_en", branch_en, 1);
        checkOutput("breq_cond", branch_cond, 1);
        checkOutput("breq_offset", branch_offset, 32'hFFE);
        sendWord(16'hFFFF, 14'h013);
        checkOutput("unknown_unsupported", unsupported, 1);
        checkOutput("unknown_rd_we", rd_write_en, 0);
        checkOutput("unknown_branch_en", branch_en, 0);

        // RJMP -1 and LDS R16,0x0260
        sendWord(16'hCFFF, 14'h014);
        checkOutput("rjmp_rel", jump_rel, 1);
        checkOutput("rjmp_addr", jump_addr, 32'h3FFFFF);
        sendWord(16'h9100, 14'h015);
        sendWord(16'h0260, 14'h016);
        checkOutput("lds_mem_read", mem_read, 1);
        checkOutput("lds_mem_addr", mem_addr, 32'h0260);
        checkOutput("lds_rd", rd_addr, 16);
        checkOutput("lds_out_pc", out_pc, 32'h015);

        // Backpressure: ADD held while LDI waits
        sendWord(16'h0C12, 14'h020);
        out_ready = 1'b0;
        applyStimulus(16'hEA0B, 14'h021, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_rd_held", rd_addr, 1);
            checkOutput("bp_alu_held", alu_op, 0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", in_ready, 1);
        stepCycle();
        in_valid = 1'b0;
        checkOutput("bp_next_rd", rd_addr, 16);
        checkOutput("bp_next_out_pc", out_pc, 32'h021);
        checkOutput("bp_next_valid", out_valid, 1);

        // Flush in WAIT_K2 after CALL word 1; offered word is discarded
        sendWord(16'h940E, 14'h030);
        flush = 1'b1;
        applyStimulus(16'h1234, 14'h031, 1'b1);
        stepCycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_out_valid", out_valid, 0);
        sendWord(16'hE000, 14'h032);
        checkOutput("flush_ldi_valid", out_valid, 1);
        checkOutput("flush_ldi_rd", rd_addr, 16);
        checkOutput("flush_ldi_imm", immediate, 0);
        checkOutput("flush_no_call", is_call, 0);
        checkOutput("flush_no_jump", jump_en, 0);
        checkOutput("flush_out_pc", out_pc, 32'h032);

        // Reset while waiting for CALL word 2
        sendWord(16'h940E, 14'h040);
        reset_n = 1'b0;
        #2;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        stepCycle();
        reset_n = 1'b1;
        sendWord(16'h0C12, 14'h050);
        checkOutput("midrst_add_valid", out_valid, 1);
        checkOutput("midrst_add_alu", alu_op, 0);
        checkOutput("midrst_no_jump", jump_en, 0);
        checkOutput("midrst_word_count", word_count, 0);
        checkOutput("midrst_out_pc", out_pc, 32'h050);

        stepCycle();
        checkOutput("drain_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/axioma_decode_stage.md
# axioma_decode_stage

Registered, handshaked AVR instruction decode stage; the next-generation replacement for the combinational decoder between the fetch unit and the execute stage of the AxiomaCore-328 pipeline. It adds valid/ready flow control, a one-entry output register, pipeline flush, and assembly of two-word instructions (JMP, CALL, LDS, STS). It also carries the fetch PC alongside each decoded instruction.

## Interface
- PC_W, 14: program-counter width in words (16K words, 32 KB flash).
- ENABLE_32BIT, 1: decode two-word instructions; when 0 they flag `unsupported`.
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous reset, active low.
- `flush` input 1: synchronous kill of pending and held state (taken branch or jump).
- `in_instr` input 16: fetched instruction word.
- `in_pc` input PC_W: word address of `in_instr`.
- `in_valid` input 1: `in_instr` and `in_pc` are valid.
- `in_ready` output 1: stage accepts a word this cycle.
- `out_valid` output 1: decoded bundle is valid.
- `out_ready` input 1: execute stage consumes the bundle.
- `out_pc` output PC_W: PC of the first word of the instruction.
- `rs1_addr`, `rs2_addr`, `rd_addr` output 5 each: register addresses.
- `rd_write_en` output 1: register write enable.
- `alu_op` output 5: ALU operation code.
- `alu_use_imm` output 1: select `immediate` instead of rs2.
- `immediate` output 8: immediate operand.
- `mem_read`, `mem_write` output 1 each: data-memory read and write.
- `mem_addr` output 16: direct data address (LDS, STS).
- `branch_en` output 1: conditional branch.
- `branch_cond` output 3: branch condition; 1 = EQ, 2 = NE.
- `branch_offset` output 12: sign-extended branch offset.
- `jump_en` output 1: jump.
- `jump_rel` output 1: 1 = relative jump (RJMP), 0 = absolute jump.
- `is_call` output 1: push return address (CALL).
- `jump_addr` output 22: jump target or sign-extended offset.
- `word_count` output 1: 0 = one-word instruction, 1 = two-word instruction.
- `unsupported` output 1: instruction not recognised.

## Operation
**Decoded subset (mask/value):**
- ADD FC00/0C00, ADC FC00/1C00, SUB FC00/1800, AND FC00/2000, EOR FC00/2400, OR FC00/2800. For all six: rd = rs1 = [8:4], rs2 = {[9],[3:0]}, write enabled.
- MOV FC00/2C00: rs1 = {[9],[3:0]}, rd = [8:4], alu_op = PASS.
- LDI F000/E000: rd = {1,[7:4]}, imm = {[11:8],[3:0]}, alu_op = PASS, alu_use_imm = 1.
- CPI F000/3000: rs1 = {1,[7:4]}, imm as for LDI, alu_op = CP, no register write.
- RJMP F000/C000: jump_en = 1, jump_rel = 1, jump_addr = sign-extend of [11:0].
- BREQ FC07/F001 and BRNE FC07/F401: branch_offset = sign-extend of [9:3].
- NOP 0000: all control outputs at their idle values.
- JMP FE0E/940C and CALL FE0E/940E: jump_addr = {[8:4],[0],word2}.
- LDS FE0F/9000 and STS FE0F/9200: rd (LDS) or rs1 (STS) = [8:4], mem_addr = word2.
- Any other word: emit the bundle with unsupported = 1 and all enables 0.

**FSM:**
- IDLE: an accepted two-word opcode latches word 1 and its PC, then goes to WAIT_K2. Any other accepted word loads the output register.
- WAIT_K2: the next accepted word is the operand; load the output register and return to IDLE.
- With ENABLE_32BIT = 0, there is no WAIT_K2 state.

**Handshake:**
- in_ready = !out_valid || out_ready, held low during reset.
- A transfer occurs when in_valid && in_ready. out_valid, if set, holds the bundle stable until out_ready.

**flush:**
- Clears out_valid and returns the FSM to IDLE.
- Discards any word offered in the same cycle.
- Has priority over every other event.

**Reset:**
- All outputs 0, except alu_op = 5'h1F (PASS).
- FSM in IDLE.
- Reset mid-operation drops any latched first word.

## Timing
- One-word instruction accepted in cycle N: out_valid rises in N+1.
- Two-word instruction: out_valid rises the cycle after word 2 is accepted. No bundle is emitted for word 1.
- Full throughput with out_ready held high: one bundle per cycle (two cycles for a two-word instruction).
- Backpressure: when out_valid && !out_ready, in_ready = 0 and the bundle stays stable.
- Simultaneous output consume and input accept: the register reloads in the same cycle, with no bubble.

## Structure
- Shared package `axioma_pkg` holds:
  - the ALU opcodes ADD 00, ADC 01, SUB 02, AND 04, OR 05, EOR 06, CP 11h, PASS 1Fh;
  - the branch condition codes;
  - the opcode mask/value constants;
  - the FSM state enum.
- Sub-module `axioma_decode_comb`: pure combinational decode of {word1, word2}. The stage wraps it with the FSM and the output register.

## Test plan
- ADD R1,R2: 0x0C12 -> next cycle out_valid = 1, rd = 1, rs1 = 1, rs2 = 2, alu_op = 00, rd_write_en = 1, word_count = 0.
- LDI R16,0xAB: 0xEA0B -> rd = 16, immediate = 0xAB, alu_use_imm = 1, alu_op = 1Fh.
- JMP 0x000123: 0x940C at pc 0x010, then 0x0123 -> one bundle with jump_addr = 0x000123, jump_rel = 0, out_pc = 0x010, word_count = 1.
- BREQ -2: 0xF3F1 -> branch_en = 1, branch_cond = 1, branch_offset = 0xFFE. Unknown word 0xFFFF -> unsupported = 1.
- Backpressure: out_ready low for 3 cycles with in_valid high -> in_ready = 0 and the bundle is unchanged. The next word is accepted the cycle out_ready rises.
- Flush in WAIT_K2 after 0x940E: the next word 0xE000 decodes as LDI R16,0, with no CALL emitted. Asserting reset_n low in WAIT_K2 gives out_valid = 0 and returns the FSM to IDLE.
